// File: rtl/window_gen_l1.sv
// 3x3 sliding-window generator fed by a pixel stream and two external row delay lines.
// Optional macro WINDOW_STRIDE2_EN restricts valid windows to even (r-2, c-2) positions.
module window_gen_l1 #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic [DATA_W-1:0]     row1_in,
  input  logic [DATA_W-1:0]     row2_in,
  input  logic                  err_clr,
  output logic                  out_valid,
  output logic [9*DATA_W-1:0]   win_out,
  output logic                  frame_done,
  output logic                  err
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t                state_r;
  logic [CW-1:0]         col_r;
  logic [RW-1:0]         row_r;
  logic [9*DATA_W-1:0]   win_r;
  logic                  out_valid_r;
  logic                  frame_done_r;
  logic                  err_r;

  logic                  accept_s;
  logic                  last_s;
  logic                  win_ok_s;
  logic [9*DATA_W-1:0]   win_nxt_s;

  // Acceptance, end-of-frame and window-validity decode for the pixel at (row_r, col_r)
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      IDLE, FILL, STREAM: accept_s = in_valid;
      default:            accept_s = 1'b0;
    endcase
    last_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
`ifdef WINDOW_STRIDE2_EN
    // (r-2) and (c-2) even is the same as r and c even
    win_ok_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO) && !row_r[0] && !col_r[0];
`else
    win_ok_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
`endif
  end

  // Next window: shift columns left, new right column is {r-2, r-1, r} at column c
  always_comb begin
    win_nxt_s = win_r;
    for (int i = 0; i < 3; i++) begin
      win_nxt_s[(3*i+0)*DATA_W +: DATA_W] = win_r[(3*i+1)*DATA_W +: DATA_W];
      win_nxt_s[(3*i+1)*DATA_W +: DATA_W] = win_r[(3*i+2)*DATA_W +: DATA_W];
    end
    win_nxt_s[2*DATA_W +: DATA_W] = row2_in;
    win_nxt_s[5*DATA_W +: DATA_W] = row1_in;
    win_nxt_s[8*DATA_W +: DATA_W] = pix_in;
  end

  // Control FSM, position counters, window register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      col_r        <= '0;
      row_r        <= '0;
      win_r        <= '0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      out_valid_r  <= accept_s && win_ok_s;
      frame_done_r <= accept_s && last_s;
      if (accept_s) begin
        win_r <= win_nxt_s;
        if (last_s) begin
          col_r   <= '0;
          row_r   <= '0;
          state_r <= IDLE;
        end else begin
          if (col_r == COL_LAST) begin
            col_r <= '0;
            row_r <= row_r + RW'(1);
          end else begin
            col_r <= col_r + CW'(1);
          end
          case (state_r)
            IDLE:    state_r <= FILL;
            FILL:    state_r <= ((row_r == ROW_TWO) && (col_r == COL_TWO)) ? STREAM : FILL;
            default: state_r <= state_r;
          endcase
        end
      end else begin
        case (state_r)
          FILL, STREAM: begin
            state_r <= ERR;
            err_r   <= 1'b1;
          end
          ERR: begin
            // err_clr wins over in_valid; the pixel offered this cycle is dropped
            if (err_clr) begin
              state_r <= IDLE;
              col_r   <= '0;
              row_r   <= '0;
              err_r   <= 1'b0;
            end else begin
              state_r <= ERR;
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign win_out    = win_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_window_gen_l1.sv
// Scoreboard bench for window_gen_l1 (5x4 image, pixel value 16*r+c, modelled row delay lines).
module tb_window_gen_l1;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 16;
`ifdef WINDOW_STRIDE2_EN
  localparam int EXP_WIN = 2;
`else
  localparam int EXP_WIN = 6;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              err_clr;
  logic [DW-1:0]     pix_in;
  logic [DW-1:0]     row1_in;
  logic [DW-1:0]     row2_in;
  logic              out_valid;
  logic [9*DW-1:0]   win_out;
  logic              frame_done;
  logic              err;

  logic [DW-1:0]     dl [0:2*W-1];
  logic [9*DW-1:0]   exp_q [$];
  int vectors     = 0;
  int miscompares = 0;
  int win_cnt     = 0;

  always #5 clk = ~clk;

  window_gen_l1 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pix_in(pix_in),
    .row1_in(row1_in), .row2_in(row2_in), .err_clr(err_clr),
    .out_valid(out_valid), .win_out(win_out), .frame_done(frame_done), .err(err)
  );

  // Upstream row delay lines: W and 2*W cycle delays of pix_in
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2*W; k++) dl[k] <= '0;
    end else begin
      dl[0] <= pix_in;
      for (int k = 1; k < 2*W; k++) dl[k] <= dl[k-1];
    end
  end
  assign row1_in = dl[W-1];
  assign row2_in = dl[2*W-1];

  task automatic check(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = DW'(16*(r-2+i) + (c-2+j));
    return w;
  endfunction

  function automatic bit win_ok(input int r, input int c);
`ifdef WINDOW_STRIDE2_EN
    return (r >= 2) && (c >= 2) && ((r % 2) == 0) && ((c % 2) == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  // Offer pixel (r,c) for one cycle, queue its expected window, check frame_done afterwards
  task automatic pix(input int r, input int c);
    in_valid = 1'b1;
    pix_in   = DW'(16*r + c);
    if (win_ok(r, c)) exp_q.push_back(exp_win(r, c));
    @(posedge clk);
    @(negedge clk);
    check("frame_done", {143'd0, frame_done}, {143'd0, (r == H-1) && (c == W-1)});
  endtask

  task automatic frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix(r, c);
  endtask

  task automatic partial(input int n);
    for (int k = 0; k < n; k++) pix(k / W, k % W);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_windows(input string name, input int start, input int n);
    idle(3);
    check(name, (win_cnt - start), n);
    check("queue empty", exp_q.size(), 0);
  endtask

  // Monitor: every presented window must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected window: got %h, expected none", win_out);
      end else begin
        check("window", win_out, exp_q.pop_front());
        win_cnt++;
      end
    end
  end

  int s;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; pix_in = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", {143'd0, out_valid}, '0);
    check("reset frame_done", {143'd0, frame_done}, '0);
    check("reset err", {143'd0, err}, '0);
    check("reset win_out", win_out, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame
    s = win_cnt;
    frame();
    chk_windows("frame1 windows", s, EXP_WIN);
    check("frame1 err", {143'd0, err}, '0);

    // Gap after (1,3), sticky err, clear, then a clean frame
    s = win_cnt;
    partial(W + 4);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("gap err", {143'd0, err}, 144'd1);
    check("gap out_valid", {143'd0, out_valid}, '0);
    repeat (2) @(negedge clk);
    check("err sticky", {143'd0, err}, 144'd1);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    check("err cleared", {143'd0, err}, '0);
    frame();
    chk_windows("post-err windows", s, EXP_WIN);

    // Asynchronous reset while pixel (2,3) is offered
    partial(2*W + 3);
    in_valid = 1'b1;
    pix_in   = DW'(16'h23);
    #1 rst_n = 1'b0;
    #1;
    check("async out_valid", {143'd0, out_valid}, '0);
    check("async frame_done", {143'd0, frame_done}, '0);
    check("async err", {143'd0, err}, '0);
    check("async win_out", win_out, '0);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = win_cnt;
    frame();
    chk_windows("post-reset windows", s, EXP_WIN);

    // Back-to-back frames
    s = win_cnt;
    frame();
    frame();
    chk_windows("b2b windows", s, 2*EXP_WIN);

    // err_clr together with in_valid in ERR: pixel must be dropped
    s = win_cnt;
    partial(4);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("gap2 err", {143'd0, err}, 144'd1);
    err_clr  = 1'b1;
    in_valid = 1'b1;
    pix_in   = '0;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    check("clr+valid err", {143'd0, err}, '0);
    check("clr+valid out_valid", {143'd0, out_valid}, '0);
    frame();
    chk_windows("clr+valid windows", s, EXP_WIN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_gen_l1.md
WINDOW_GEN_L1 -- requirements
Module: window_gen_l1

Interface
REQ-001 Parameter IMG_WIDTH, default 28, pixels per row; equals the DEPTH of the upstream row delay lines.
REQ-002 Parameter IMG_HEIGHT, default 28, rows per frame.
REQ-003 Parameter DATA_W, default 16, pixel width.
REQ-004 Port clk  input  1  single clock, all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  frame pixel stream active; held high for exactly IMG_WIDTH*IMG_HEIGHT consecutive cycles per frame.
REQ-007 Port pix_in  input  DATA_W  current pixel (r,c).
REQ-008 Port row1_in  input  DATA_W  pixel (r-1,c), from first row delay line.
REQ-009 Port row2_in  input  DATA_W  pixel (r-2,c), from second row delay line.
REQ-010 Port err_clr  input  1  clears error state.
REQ-011 Port out_valid  output  1  win_out holds a valid 3x3 window.
REQ-012 Port win_out  output  9*DATA_W  window; slice k=3*i+j holds pixel (r-2+i, c-2+j).
REQ-013 Port frame_done  output  1  one-cycle pulse after last frame pixel accepted.
REQ-014 Port err  output  1  stream gap detected; sticky.

Function
REQ-015 FSM states IDLE, FILL, STREAM, ERR.
REQ-016 IDLE: in_valid=1 accepts pixel (0,0), -> FILL.
REQ-017 FILL -> STREAM when pixel (2,2) accepted.
REQ-018 FILL/STREAM: pixel (IMG_HEIGHT-1, IMG_WIDTH-1) accepted -> IDLE; frame_done=1 next cycle only.
REQ-019 FILL/STREAM: in_valid=0 -> ERR; err=1 next cycle; counters and window retained, out_valid=0.
REQ-020 ERR: in_valid ignored; err_clr=1 -> IDLE, counters zeroed, err=0 next cycle; err_clr takes priority over simultaneous in_valid (pixel not accepted).
REQ-021 err_clr outside ERR has no effect.
REQ-022 Column counter 0..IMG_WIDTH-1, wraps to 0 and increments row counter; row counter 0..IMG_HEIGHT-1, both width $clog2 of their maximum, zeroed on return to IDLE.
REQ-023 Window register: each accepted pixel shifts columns left (col0<=col1, col1<=col2), col2 loaded from {row2_in, row1_in, pix_in} for rows 0,1,2.
REQ-024 out_valid=1 the cycle after accepting pixel (r,c) with r>=2 and c>=2, else 0; latency one cycle.
REQ-025 Windows spanning a row wrap (c<2) are never flagged valid.
REQ-026 Per frame exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) valid windows, row-major order.
REQ-027 Back-to-back frames: in_valid high in the cycle after the last pixel starts the next frame from IDLE without bubble.

Reset
REQ-028 rst_n=0 immediately forces IDLE, counters 0, window registers 0, out_valid=0, frame_done=0, err=0, win_out=0.
REQ-029 Reset mid-frame discards the partial frame; first in_valid after release is pixel (0,0).

Configuration
REQ-030 Macro WINDOW_STRIDE2_EN defined: out_valid additionally requires (r-2) and (c-2) both even; (ceil((IMG_HEIGHT-2)/2))*(ceil((IMG_WIDTH-2)/2)) windows per frame (169 at default).
REQ-031 Macro undefined: stride 1 per REQ-024; no stride logic synthesized.

Verification (bench models row1_in/row2_in as IMG_WIDTH and 2*IMG_WIDTH cycle delays of pix_in; pixel value = 16*r+c; IMG_WIDTH=5, IMG_HEIGHT=4)
REQ-032 One full frame -> 6 out_valid pulses; first window after pixel (2,2) = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22}; last after (3,4) = {0x12..0x34}; frame_done one cycle after pixel (3,4).
REQ-033 in_valid drops after pixel (1,3) -> err=1 next cycle, no out_valid; err_clr -> err=0, IDLE; next frame produces 6 correct windows.
REQ-034 rst_n low during pixel (2,3) -> all outputs 0 asynchronously; fresh frame after release yields 6 correct windows.
REQ-035 Two frames back-to-back -> 12 windows, frame_done pulses twice, second frame's first window starts 0x00.
REQ-036 WINDOW_STRIDE2_EN defined, same frame -> out_valid only after pixels (2,2) and (2,4); 2 windows.
REQ-037 err_clr and in_valid both high in ERR -> IDLE, pixel not counted; frame starting next cycle windows correct.
